// File: rtl/uart_cmd_frame_tx_pkg.sv
// Shared framing definitions for the UART command link (both TX and RX directions).
// Holds frame delimiters, the parameter-count limit and the FSM state encodings.
package uart_cmd_frame_tx_pkg;

  localparam logic [7:0] FRAME_HEADER_BYTE = 8'hA5;
  localparam logic [7:0] FRAME_TAIL_BYTE   = 8'h5A;

  // The command receiver matches on the same delimiters as this transmitter emits.
  localparam logic [7:0] RX_HEADER_BYTE = FRAME_HEADER_BYTE;
  localparam logic [7:0] RX_TAIL_BYTE   = FRAME_TAIL_BYTE;

  localparam int MAX_PARAMS = 4;

  typedef enum logic [2:0] {
    FR_IDLE,
    FR_HDR,
    FR_CMD,
    FR_LEN,
    FR_PARAM,
    FR_CSUM,
    FR_TAIL,
    FR_DONE
  } frame_state_e;

  typedef enum logic [1:0] {
    BT_IDLE,
    BT_START,
    BT_DATA,
    BT_STOP
  } byte_state_e;

  function automatic logic [2:0] clamp_len(input logic [7:0] len);
    return (len > 8'(MAX_PARAMS)) ? 3'(MAX_PARAMS) : len[2:0];
  endfunction

endpackage

// File: rtl/uart_cmd_frame_tx_byte.sv
// 8N1 byte serialiser, LSB first, with back-to-back byte chaining.
// byte_data is captured at the end of the start bit, so it must be stable by then.
module uart_byte_tx
  import uart_cmd_frame_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       byte_ready,
  output logic       byte_done,
  output logic       uart_tx
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  byte_state_e      state;
  logic [CNT_W-1:0] baud_cnt;
  logic [3:0]       bit_idx;
  logic [7:0]       shift_q;
  logic             bit_end;

  assign bit_end    = (baud_cnt == CNT_LAST);
  assign byte_done  = (state == BT_STOP) && bit_end;
  assign byte_ready = (state == BT_IDLE) || byte_done;

  // A new byte may start straight out of the stop bit, leaving no idle gap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= BT_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift_q  <= '0;
      uart_tx  <= 1'b1;
    end else begin
      case (state)
        BT_IDLE: begin
          baud_cnt <= '0;
          if (byte_valid) begin
            state   <= BT_START;
            uart_tx <= 1'b0;
            bit_idx <= 4'd0;
          end
        end
        BT_START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            shift_q  <= {1'b0, byte_data[7:1]};
            uart_tx  <= byte_data[0];
            bit_idx  <= 4'd1;
            state    <= BT_DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        BT_DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            bit_idx  <= bit_idx + 4'd1;
            if (bit_idx == 4'd8) begin
              state   <= BT_STOP;
              uart_tx <= 1'b1;
            end else begin
              uart_tx <= shift_q[0];
              shift_q <= {1'b0, shift_q[7:1]};
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        BT_STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (byte_valid) begin
              state   <= BT_START;
              uart_tx <= 1'b0;
              bit_idx <= 4'd0;
            end else begin
              state <= BT_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          state   <= BT_IDLE;
          uart_tx <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_cmd_frame_tx.sv
// Command/status frame transmitter: HEADER, code, len, params (MSB first), checksum, TAIL.
// Frame sequencing and checksum live here; bit timing is delegated to uart_byte_tx.
module uart_cmd_frame_tx
  import uart_cmd_frame_tx_pkg::*;
#(
  parameter int         CLK_FREQ      = 50000000,
  parameter int         UART_BPS_RATE = 115200,
  parameter int         CLKS_PER_BIT  = CLK_FREQ / UART_BPS_RATE,
  parameter logic [7:0] HEADER_BYTE   = FRAME_HEADER_BYTE,
  parameter logic [7:0] TAIL_BYTE     = FRAME_TAIL_BYTE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tx_valid,
  output logic        tx_ready,
  input  logic [7:0]  cmdcode,
  input  logic [7:0]  cmd_len,
  input  logic [31:0] para_list,
  output logic        uart_tx,
  output logic        busy,
  output logic        done
);

  frame_state_e state;
  logic [7:0]   cmd_q;
  logic [2:0]   len_q;
  logic [31:0]  para_q;
  logic [7:0]   csum_q;
  logic [1:0]   param_idx;
  logic         tx_ready_q;
  logic         done_q;

  logic         accept;
  logic         in_byte_state;
  logic         byte_valid;
  logic         byte_ready;
  logic         byte_done;
  logic [7:0]   byte_data;
  logic [7:0]   param_byte;

  assign accept        = tx_valid && tx_ready_q;
  assign param_byte    = para_q[{param_idx, 3'b000} +: 8];
  assign in_byte_state = (state inside {[FR_HDR:FR_TAIL]});
  // The tail is the last byte: do not let the serialiser chain another one after it.
  assign byte_valid    = byte_ready && in_byte_state && !((state == FR_TAIL) && byte_done);

  assign tx_ready = tx_ready_q;
  assign busy     = ~tx_ready_q;
  assign done     = done_q;

  always_comb begin
    byte_data = 8'hFF;
    case (state)
      FR_HDR:   byte_data = HEADER_BYTE;
      FR_CMD:   byte_data = cmd_q;
      FR_LEN:   byte_data = {5'b00000, len_q};
      FR_PARAM: byte_data = param_byte;
      FR_CSUM:  byte_data = csum_q;
      FR_TAIL:  byte_data = TAIL_BYTE;
      default:  byte_data = 8'hFF;
    endcase
  end

  // Checksum is seeded with code+len at acceptance and accumulates each parameter as it goes out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= FR_IDLE;
      cmd_q      <= '0;
      len_q      <= '0;
      para_q     <= '0;
      csum_q     <= '0;
      param_idx  <= '0;
      tx_ready_q <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        FR_IDLE, FR_DONE: begin
          if (accept) begin
            cmd_q      <= cmdcode;
            len_q      <= clamp_len(cmd_len);
            para_q     <= para_list;
            csum_q     <= cmdcode + {5'b00000, clamp_len(cmd_len)};
            tx_ready_q <= 1'b0;
            state      <= FR_HDR;
          end else begin
            state <= FR_IDLE;
          end
        end
        FR_HDR: if (byte_done) state <= FR_CMD;
        FR_CMD: if (byte_done) state <= FR_LEN;
        FR_LEN: begin
          if (byte_done) begin
            if (len_q == 3'd0) begin
              state <= FR_CSUM;
            end else begin
              param_idx <= 2'(len_q - 3'd1);
              state     <= FR_PARAM;
            end
          end
        end
        FR_PARAM: begin
          if (byte_done) begin
            csum_q <= csum_q + param_byte;
            if (param_idx == 2'd0) state <= FR_CSUM;
            else param_idx <= param_idx - 2'd1;
          end
        end
        FR_CSUM: if (byte_done) state <= FR_TAIL;
        FR_TAIL: begin
          if (byte_done) begin
            state      <= FR_DONE;
            done_q     <= 1'b1;
            tx_ready_q <= 1'b1;
          end
        end
        default: begin
          state      <= FR_IDLE;
          tx_ready_q <= 1'b1;
        end
      endcase
    end
  end

  uart_byte_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte_tx (
    .clk       (clk),
    .rst       (rst),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .byte_ready(byte_ready),
    .byte_done (byte_done),
    .uart_tx   (uart_tx)
  );

endmodule

// File: tb/tb_uart_cmd_frame_tx.sv
// Testbench for uart_cmd_frame_tx: decodes the serial line and compares against a frame model.
// Runs with a short bit period so that many frames fit in a small cycle budget.
module tb_uart_cmd_frame_tx;

  localparam int CPB      = 16;
  localparam int BPS      = 115200;
  localparam int CLK_FREQ = CPB * BPS;
  localparam int BUDGET   = 9 * 10 * CPB + 200;

  logic        clk = 1'b0;
  logic        rst;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  cmdcode;
  logic [7:0]  cmd_len;
  logic [31:0] para_list;
  logic        uart_tx;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] exp_q[$];
  logic [7:0] rx_bytes[$];
  int         rx_starts[$];
  bit         mon_active = 1'b0;
  int         mon_cnt = 0;
  int         mon_start = 0;
  logic [7:0] mon_shift = 8'h00;
  int         framing_errs = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  uart_cmd_frame_tx #(
    .CLK_FREQ     (CLK_FREQ),
    .UART_BPS_RATE(BPS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .cmdcode  (cmdcode),
    .cmd_len  (cmd_len),
    .para_list(para_list),
    .uart_tx  (uart_tx),
    .busy     (busy),
    .done     (done)
  );

  // Line decoder: samples mid-bit, records each byte and the cycle its start bit was first seen.
  always @(negedge clk) begin
    if (rst) begin
      mon_active <= 1'b0;
    end else if (!mon_active) begin
      if (uart_tx == 1'b0) begin
        mon_active <= 1'b1;
        mon_cnt    <= 1;
        mon_start  <= cyc;
      end
    end else begin
      mon_cnt <= mon_cnt + 1;
      if (mon_cnt >= CPB / 2 && ((mon_cnt - CPB / 2) % CPB) == 0) begin
        if ((mon_cnt - CPB / 2) / CPB == 0) begin
          if (uart_tx !== 1'b0) framing_errs <= framing_errs + 1;
        end else if ((mon_cnt - CPB / 2) / CPB <= 8) begin
          mon_shift <= {uart_tx, mon_shift[7:1]};
        end else begin
          rx_bytes.push_back(mon_shift);
          rx_starts.push_back(mon_start);
          if (uart_tx !== 1'b1) framing_errs <= framing_errs + 1;
          mon_active <= 1'b0;
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic modelFrame(input logic [7:0] c, input logic [7:0] n, input logic [31:0] p);
    int l;
    int sum;
    logic [7:0] b;
    l = (n > 8'd4) ? 4 : int'(n);
    exp_q.delete();
    exp_q.push_back(8'hA5);
    exp_q.push_back(c);
    exp_q.push_back(8'(l));
    sum = int'(c) + l;
    for (int i = l - 1; i >= 0; i--) begin
      b = p[8*i +: 8];
      exp_q.push_back(b);
      sum = sum + int'(b);
    end
    exp_q.push_back(8'(sum % 256));
    exp_q.push_back(8'h5A);
  endtask

  task automatic applyStimulus(input logic [7:0] c, input logic [7:0] n, input logic [31:0] p,
                               input bit hold, output int acc);
    int w;
    w = 0;
    while (tx_ready !== 1'b1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    checkOutput("ready_before_frame", {31'd0, tx_ready}, 32'd1);
    modelFrame(c, n, p);
    rx_bytes.delete();
    rx_starts.delete();
    cmdcode   = c;
    cmd_len   = n;
    para_list = p;
    tx_valid  = 1'b1;
    @(negedge clk);
    acc = cyc;
    checkOutput("ready_drop", {31'd0, tx_ready}, 32'd0);
    checkOutput("busy_rise", {31'd0, busy}, 32'd1);
    if (!hold) begin
      tx_valid  = 1'b0;
      cmdcode   = 8'($urandom);
      cmd_len   = 8'($urandom);
      para_list = $urandom;
    end
  endtask

  task automatic waitDone(output int d);
    int w;
    w = 0;
    while (done !== 1'b1 && w < BUDGET) begin
      @(negedge clk);
      w++;
    end
    d = cyc;
    checkOutput("done_seen", {31'd0, done}, 32'd1);
    checkOutput("ready_at_done", {31'd0, tx_ready}, 32'd1);
    checkOutput("busy_at_done", {31'd0, busy}, 32'd0);
  endtask

  task automatic expectFrame(input int acc, input int d);
    checkOutput("byte_count", rx_bytes.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_bytes.size(); i++)
      checkOutput($sformatf("byte%0d", i), {24'd0, rx_bytes[i]}, {24'd0, exp_q[i]});
    if (rx_starts.size() > 0) begin
      checkOutput("start_latency", rx_starts[0], acc + 1);
      checkOutput("frame_duration", d - rx_starts[0], exp_q.size() * 10 * CPB);
    end
    checkOutput("framing", framing_errs, 0);
  endtask

  task automatic finishDone();
    @(negedge clk);
    checkOutput("done_one_cycle", {31'd0, done}, 32'd0);
  endtask

  initial begin
    int acc;
    int acc2;
    int d;
    int w;
    logic [7:0]  rc;
    logic [7:0]  rn;
    logic [31:0] rp;

    rst       = 1'b1;
    tx_valid  = 1'b0;
    cmdcode   = 8'h00;
    cmd_len   = 8'h00;
    para_list = 32'h0;
    repeat (3) @(negedge clk);
    checkOutput("reset_uart_tx", {31'd0, uart_tx}, 32'd1);
    checkOutput("reset_tx_ready", {31'd0, tx_ready}, 32'd1);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_done", {31'd0, done}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    applyStimulus(8'h01, 8'd2, 32'h0000_1234, 1'b0, acc);
    waitDone(d);
    expectFrame(acc, d);
    if (rx_bytes.size() > 5) checkOutput("csum_example", {24'd0, rx_bytes[5]}, 32'h49);
    finishDone();

    applyStimulus(8'h10, 8'd0, 32'hDEAD_BEEF, 1'b0, acc);
    @(negedge clk);
    w = 0;
    while (uart_tx === 1'b0 && w < 4 * CPB) begin
      w++;
      @(negedge clk);
    end
    checkOutput("start_bit_width", w, CPB);
    waitDone(d);
    expectFrame(acc, d);
    finishDone();

    applyStimulus(8'h03, 8'd7, 32'h1122_3344, 1'b0, acc);
    waitDone(d);
    expectFrame(acc, d);
    finishDone();

    applyStimulus(8'hFF, 8'd4, 32'hFFFF_FFFF, 1'b0, acc);
    repeat (3 * CPB) @(negedge clk);
    tx_valid  = 1'b1;
    cmdcode   = 8'h77;
    cmd_len   = 8'd1;
    para_list = 32'h0000_0055;
    @(negedge clk);
    checkOutput("busy_ignores_valid", {31'd0, tx_ready}, 32'd0);
    tx_valid = 1'b0;
    waitDone(d);
    expectFrame(acc, d);
    finishDone();

    applyStimulus(8'h01, 8'd0, 32'h0, 1'b1, acc);
    waitDone(d);
    cmdcode = 8'h02;
    expectFrame(acc, d);
    @(negedge clk);
    acc2 = cyc;
    checkOutput("b2b_done_pulse", {31'd0, done}, 32'd0);
    checkOutput("b2b_accepted", {31'd0, tx_ready}, 32'd0);
    tx_valid = 1'b0;
    rx_bytes.delete();
    rx_starts.delete();
    modelFrame(8'h02, 8'd0, 32'h0);
    waitDone(d);
    expectFrame(acc2, d);
    checkOutput("b2b_gap", acc2 + 1 - (acc + 1 + 5 * 10 * CPB), 2);
    finishDone();

    rc = 8'($urandom);
    rp = $urandom;
    applyStimulus(rc, 8'd3, rp, 1'b0, acc);
    while (cyc < acc + 1 + 23 * CPB) @(negedge clk);
    checkOutput("bytes_before_reset", rx_bytes.size(), 2);
    rst = 1'b1;
    #1;
    checkOutput("midreset_uart_tx", {31'd0, uart_tx}, 32'd1);
    checkOutput("midreset_tx_ready", {31'd0, tx_ready}, 32'd1);
    checkOutput("midreset_done", {31'd0, done}, 32'd0);
    checkOutput("midreset_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    rx_bytes.delete();
    rx_starts.delete();
    repeat (12 * CPB) @(negedge clk);
    checkOutput("no_partial_byte", rx_bytes.size(), 0);
    checkOutput("idle_after_reset", {31'd0, uart_tx}, 32'd1);
    applyStimulus(8'h5C, 8'd1, 32'h0000_00A7, 1'b0, acc);
    waitDone(d);
    expectFrame(acc, d);
    finishDone();

    for (int k = 0; k < 4; k++) begin
      rc = 8'($urandom);
      rn = 8'($urandom_range(0, 7));
      rp = $urandom;
      applyStimulus(rc, rn, rp, 1'b0, acc);
      waitDone(d);
      expectFrame(acc, d);
      finishDone();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
